op_mode_scheduler: RTL and testbench
====================================

// Module: op_mode_scheduler
// PURPOSE
//  Sequences changes of the datapath operating mode (OP_MODE, STM_GAIN_MODE) so they take effect
//  only between 40 kHz frames, never mid-frame. Captures a mode-change request, waits for a frame
//  trigger, and optionally waits for a given STM finish index. It then waits until the pipeline
//  has emitted all DEPTH transducer samples of that frame, and commits. Sits between controller
//  and normal/STM mux, driving the mux OP_MODE and the STM operator STM_GAIN_MODE.
// PARAMETERS
//  DEPTH           249    transducer samples (DIN_VALID pulses) per frame
//  TIMEOUT_CYCLES  65535  max cycles BUSY may stay high before a forced commit; >=2, fits in 20 bits
// PORTS
//  CLK_L               in   1   pipeline clock, all logic on rising edge
//  RST_N               in   1   asynchronous, active-low reset
//  REQ                 in   1   one-cycle request strobe; REQ_* sampled with it
//  REQ_OP_MODE         in   1   requested OP_MODE (0 normal, 1 STM)
//  REQ_STM_GAIN_MODE   in   1   requested STM_GAIN_MODE
//  REQ_USE_FINISH_IDX  in   1   1: switch only at a trigger where STM_IDX == REQ_FINISH_IDX
//  REQ_FINISH_IDX      in   16  STM index at which switching is allowed
//  TRIG_40KHZ          in   1   frame-start strobe
//  DIN_VALID           in   1   one pulse per transducer sample leaving the mux
//  STM_IDX             in   16  current STM index
//  OP_MODE             out  1   committed operating mode
//  STM_GAIN_MODE       out  1   committed STM gain mode
//  BUSY                out  1   request pending
//  DONE                out  1   one-cycle pulse on commit
//  TIMED_OUT           out  1   one-cycle pulse coincident with DONE when commit was forced
// BEHAVIOUR
//  Reset (RST_N=0, async): all outputs 0. State IDLE. Shadow regs, valid count and timeout count are 0.
//  States: IDLE, WAIT_TRIG, DRAIN. All outputs are registered.
//  IDLE: REQ=1 -> capture REQ_* into shadow regs; BUSY=1 from next cycle; enter WAIT_TRIG.
//    A REQ in the cycle DONE is high is accepted normally.
//  REQ while BUSY=1: ignored entirely. Shadow is unchanged, with no error indication.
//  WAIT_TRIG, on TRIG_40KHZ=1:
//    If shadow USE_FINISH_IDX=1, OP_MODE=1 and STM_IDX!=shadow FINISH_IDX, stay in WAIT_TRIG.
//    Otherwise enter DRAIN with valid count=0.
//    The finish-index check applies only when currently in STM mode (OP_MODE=1).
//  DRAIN: valid count increments on each DIN_VALID. A DIN_VALID coincident with the entering
//    trigger is not counted. TRIG_40KHZ is ignored in DRAIN.
//  Commit: on the edge that samples the DEPTH-th counted DIN_VALID:
//    OP_MODE/STM_GAIN_MODE <= shadow, DONE <= 1, BUSY <= 0, state <= IDLE.
//    New mode is visible the cycle after the last sample of the frame.
//  Timeout: the counter clears on REQ acceptance and increments every cycle in WAIT_TRIG/DRAIN.
//    When count == TIMEOUT_CYCLES-1, the commit happens on that edge with TIMED_OUT=1.
//    DONE is therefore high exactly TIMEOUT_CYCLES cycles after BUSY rose.
//    If the DEPTH-th valid and the timeout land on the same edge, it is a single commit with TIMED_OUT=1.
//  Requests equal to the current mode run the full sequence; DONE timing is identical.
//  DONE and TIMED_OUT are 0 in every cycle except the commit pulse.
//  Counters saturate-free: valid count 9 bits (DEPTH<=511), timeout count 20 bits.
// TESTING
//  1 Reset: drive REQ/TRIG/DIN_VALID randomly with RST_N=0 -> all outputs 0. After RST_N=1 with no REQ -> stay 0.
//  2 Normal->STM: REQ with OP_MODE=1, GAIN=1. TRIG 10 cycles later, then 249 DIN_VALID pulses.
//      -> OP_MODE=1, GAIN=1 and DONE=1 the cycle after the 249th pulse. BUSY 1->0 same cycle. TIMED_OUT=0.
//  3 Finish idx: OP_MODE=1. REQ OP_MODE=0, USE_FINISH_IDX=1, IDX=5. TRIGs with STM_IDX 3,4 -> no drain.
//      TRIG with STM_IDX=5 plus 249 valids -> OP_MODE=0, DONE.
//  4 Timeout: TIMEOUT_CYCLES=100, REQ OP_MODE=1, no TRIG -> DONE=TIMED_OUT=1 exactly 100 cycles after BUSY rose. OP_MODE=1.
//  5 REQ OP_MODE=1 then REQ OP_MODE=0 while BUSY -> commit yields OP_MODE=1, single DONE.
//  6 RST_N=0 mid-DRAIN after 100 valids -> outputs 0 immediately. No DONE. Next REQ follows scenario 2 timing.

Source files
------------

// File: rtl/op_mode_scheduler.sv
// op_mode_scheduler
//   Sequences datapath mode changes (OP_MODE, STM_GAIN_MODE) so they only take
//   effect between 40 kHz frames. A request is captured into shadow registers.
//   The block then waits for a frame trigger, and optionally for a matching STM
//   finish index. It lets the pipeline emit all DEPTH samples of that frame
//   and then commits. A timeout forces the commit if the sequence stalls.
//
//   Ports
//     CLK_L               pipeline clock, rising edge
//     RST_N               asynchronous active-low reset
//     REQ                 one-cycle request strobe, REQ_* sampled with it
//     REQ_OP_MODE         requested OP_MODE (0 normal, 1 STM)
//     REQ_STM_GAIN_MODE   requested STM_GAIN_MODE
//     REQ_USE_FINISH_IDX  switch only at a trigger where STM_IDX == REQ_FINISH_IDX
//     REQ_FINISH_IDX      STM index at which switching is allowed
//     TRIG_40KHZ          frame-start strobe
//     DIN_VALID           one pulse per transducer sample leaving the mux
//     STM_IDX             current STM index
//     OP_MODE             committed operating mode
//     STM_GAIN_MODE       committed STM gain mode
//     BUSY                request pending
//     DONE                one-cycle pulse on commit
//     TIMED_OUT           one-cycle pulse with DONE when the commit was forced
module op_mode_scheduler #(
    parameter int unsigned DEPTH          = 249,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK_L,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        REQ_OP_MODE,
    input  logic        REQ_STM_GAIN_MODE,
    input  logic        REQ_USE_FINISH_IDX,
    input  logic [15:0] REQ_FINISH_IDX,
    input  logic        TRIG_40KHZ,
    input  logic        DIN_VALID,
    input  logic [15:0] STM_IDX,
    output logic        OP_MODE,
    output logic        STM_GAIN_MODE,
    output logic        BUSY,
    output logic        DONE,
    output logic        TIMED_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_DRAIN
    } state_e;

    localparam logic [8:0]  VCNT_LAST = 9'(DEPTH - 1);
    localparam logic [19:0] TCNT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        op_mode_q;
    logic        gain_q;
    logic        busy_q;
    logic        done_q;
    logic        timed_out_q;
    logic        sh_op_mode_q;
    logic        sh_gain_q;
    logic        sh_use_idx_q;
    logic [15:0] sh_idx_q;
    logic [8:0]  vcnt_q;
    logic [19:0] tcnt_q;

    logic tmo_hit;
    logic last_valid;
    logic trig_ok;

    // tcnt_q holds the number of pending edges already elapsed, so reaching
    // TCNT_LAST puts DONE exactly TIMEOUT_CYCLES cycles after BUSY rose.
    assign tmo_hit    = (tcnt_q == TCNT_LAST);
    assign last_valid = DIN_VALID && (vcnt_q == VCNT_LAST);
    // The finish index only gates the switch while currently in STM mode.
    assign trig_ok    = !(sh_use_idx_q && op_mode_q && (STM_IDX != sh_idx_q));

    always_ff @(posedge CLK_L or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            op_mode_q    <= 1'b0;
            gain_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            sh_op_mode_q <= 1'b0;
            sh_gain_q    <= 1'b0;
            sh_use_idx_q <= 1'b0;
            sh_idx_q     <= '0;
            vcnt_q       <= '0;
            tcnt_q       <= '0;
        end else begin
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (REQ) begin
                        sh_op_mode_q <= REQ_OP_MODE;
                        sh_gain_q    <= REQ_STM_GAIN_MODE;
                        sh_use_idx_q <= REQ_USE_FINISH_IDX;
                        sh_idx_q     <= REQ_FINISH_IDX;
                        busy_q       <= 1'b1;
                        tcnt_q       <= '0;
                        vcnt_q       <= '0;
                        state_q      <= ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (tmo_hit) begin
                        op_mode_q   <= sh_op_mode_q;
                        gain_q      <= sh_gain_q;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        timed_out_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 20'd1;
                        // A DIN_VALID on the entering trigger is not counted.
                        if (TRIG_40KHZ && trig_ok) begin
                            vcnt_q  <= '0;
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tmo_hit || last_valid) begin
                        op_mode_q   <= sh_op_mode_q;
                        gain_q      <= sh_gain_q;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        timed_out_q <= tmo_hit;
                        state_q     <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 20'd1;
                        if (DIN_VALID) begin
                            vcnt_q <= vcnt_q + 9'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign OP_MODE       = op_mode_q;
    assign STM_GAIN_MODE = gain_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign TIMED_OUT     = timed_out_q;

endmodule

// File: tb/tb_op_mode_scheduler.sv
// Testbench for op_mode_scheduler: directed scenarios plus a randomized phase,
// every cycle compared against a transaction-level reference model.
module tb_op_mode_scheduler;

    localparam int unsigned DEPTH = 249;
    localparam int unsigned TMO   = 300;

    logic        CLK_L = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ = 1'b0;
    logic        REQ_OP_MODE = 1'b0;
    logic        REQ_STM_GAIN_MODE = 1'b0;
    logic        REQ_USE_FINISH_IDX = 1'b0;
    logic [15:0] REQ_FINISH_IDX = '0;
    logic        TRIG_40KHZ = 1'b0;
    logic        DIN_VALID = 1'b0;
    logic [15:0] STM_IDX = '0;
    logic        OP_MODE;
    logic        STM_GAIN_MODE;
    logic        BUSY;
    logic        DONE;
    logic        TIMED_OUT;

    op_mode_scheduler #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK_L              (CLK_L),
        .RST_N              (RST_N),
        .REQ                (REQ),
        .REQ_OP_MODE        (REQ_OP_MODE),
        .REQ_STM_GAIN_MODE  (REQ_STM_GAIN_MODE),
        .REQ_USE_FINISH_IDX (REQ_USE_FINISH_IDX),
        .REQ_FINISH_IDX     (REQ_FINISH_IDX),
        .TRIG_40KHZ         (TRIG_40KHZ),
        .DIN_VALID          (DIN_VALID),
        .STM_IDX            (STM_IDX),
        .OP_MODE            (OP_MODE),
        .STM_GAIN_MODE      (STM_GAIN_MODE),
        .BUSY               (BUSY),
        .DONE               (DONE),
        .TIMED_OUT          (TIMED_OUT)
    );

    always #5 CLK_L = ~CLK_L;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A request is pending from its acceptance edge; it completes either when
    // the frame it latched onto has delivered DEPTH samples, or when TMO edges
    // have passed since acceptance (forced).
    bit          m_op = 0, m_gain = 0, m_pend = 0, m_done = 0, m_to = 0;
    bit          m_drain = 0;
    int          m_samples = 0;
    int          m_edge = 0;
    int          m_since = 0;
    bit          s_op = 0, s_gain = 0, s_use = 0;
    logic [15:0] s_idx = '0;

    always @(posedge CLK_L or negedge RST_N) begin : model
        bit forced, full, blocked;
        if (!RST_N) begin
            m_op = 0; m_gain = 0; m_pend = 0; m_done = 0; m_to = 0;
            m_drain = 0; m_samples = 0;
        end else begin
            m_edge++;
            m_done = 0;
            m_to   = 0;
            if (!m_pend) begin
                if (REQ) begin
                    m_pend  = 1;
                    m_since = m_edge;
                    m_drain = 0;
                    s_op = REQ_OP_MODE; s_gain = REQ_STM_GAIN_MODE;
                    s_use = REQ_USE_FINISH_IDX; s_idx = REQ_FINISH_IDX;
                end
            end else begin
                forced = (m_edge - m_since) == int'(TMO);
                full   = m_drain && DIN_VALID && (m_samples + 1 == int'(DEPTH));
                if (forced || full) begin
                    m_op = s_op; m_gain = s_gain;
                    m_pend = 0; m_done = 1; m_to = forced; m_drain = 0;
                end else if (m_drain) begin
                    if (DIN_VALID) m_samples++;
                end else if (TRIG_40KHZ) begin
                    blocked = s_use && m_op && (STM_IDX != s_idx);
                    if (!blocked) begin
                        m_drain   = 1;
                        m_samples = 0;
                    end
                end
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge CLK_L) begin
        if (cmp_en) begin
            chk("op_mode",   32'(OP_MODE),       32'(m_op));
            chk("gain",      32'(STM_GAIN_MODE), 32'(m_gain));
            chk("busy",      32'(BUSY),          32'(m_pend));
            chk("done",      32'(DONE),          32'(m_done));
            chk("timed_out", 32'(TIMED_OUT),     32'(m_to));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_L);
            #1;
        end
    endtask

    task automatic issue(input bit op, input bit gain, input bit use_idx, input logic [15:0] idx);
        REQ = 1; REQ_OP_MODE = op; REQ_STM_GAIN_MODE = gain;
        REQ_USE_FINISH_IDX = use_idx; REQ_FINISH_IDX = idx;
        step();
        REQ = 0;
    endtask

    task automatic trig(input logic [15:0] idx);
        STM_IDX = idx; TRIG_40KHZ = 1;
        step();
        TRIG_40KHZ = 0;
    endtask

    task automatic valids(input int n);
        DIN_VALID = 1;
        step(n);
        DIN_VALID = 0;
    endtask

    initial begin
        // 1: reset with random activity on the inputs
        cmp_en = 1;
        for (int i = 0; i < 20; i++) begin
            REQ = 1'($urandom); TRIG_40KHZ = 1'($urandom); DIN_VALID = 1'($urandom);
            REQ_OP_MODE = 1'($urandom);
            step();
        end
        REQ = 0; TRIG_40KHZ = 0; DIN_VALID = 0;
        RST_N = 1;
        step(5);
        chk("rst_op", 32'(OP_MODE), 0);
        chk("rst_busy", 32'(BUSY), 0);

        // 2: normal -> STM
        issue(1, 1, 0, 0);
        step(9);
        trig(0);
        valids(DEPTH - 1);
        chk("s2_early_done", 32'(DONE), 0);
        valids(1);
        chk("s2_done", 32'(DONE), 1);
        chk("s2_op", 32'(OP_MODE), 1);
        chk("s2_gain", 32'(STM_GAIN_MODE), 1);
        chk("s2_busy", 32'(BUSY), 0);
        chk("s2_to", 32'(TIMED_OUT), 0);
        step(3);

        // 3: finish index gate while in STM mode
        issue(0, 1, 1, 16'd5);
        trig(3);
        step(2);
        trig(4);
        valids(5);
        chk("s3_busy_hold", 32'(BUSY), 1);
        trig(5);
        valids(DEPTH);
        chk("s3_done", 32'(DONE), 1);
        chk("s3_op", 32'(OP_MODE), 0);
        step(3);

        // 5: second REQ while busy is ignored
        issue(1, 0, 0, 0);
        issue(0, 1, 0, 0);
        trig(0);
        valids(DEPTH);
        chk("s5_done", 32'(DONE), 1);
        chk("s5_op", 32'(OP_MODE), 1);
        chk("s5_gain", 32'(STM_GAIN_MODE), 0);
        step();
        chk("s5_single_done", 32'(DONE), 0);
        step(2);

        // 4: timeout with no trigger
        issue(1, 1, 0, 0);
        step(TMO - 1);
        chk("s4_before", 32'(DONE), 0);
        step();
        chk("s4_done", 32'(DONE), 1);
        chk("s4_to", 32'(TIMED_OUT), 1);
        chk("s4_op", 32'(OP_MODE), 1);
        step(3);

        // 6: reset mid-drain, then a clean request
        issue(0, 0, 0, 0);
        trig(0);
        valids(100);
        RST_N = 0;
        #2;
        chk("s6_op", 32'(OP_MODE), 0);
        chk("s6_gain", 32'(STM_GAIN_MODE), 0);
        chk("s6_busy", 32'(BUSY), 0);
        chk("s6_done", 32'(DONE), 0);
        step(2);
        RST_N = 1;
        step(2);
        issue(1, 1, 0, 0);
        step(9);
        trig(0);
        valids(DEPTH);
        chk("s6_re_done", 32'(DONE), 1);
        chk("s6_re_op", 32'(OP_MODE), 1);
        step(2);

        // randomized phase
        for (int i = 0; i < 6000; i++) begin
            REQ                = ($urandom_range(0, 19) == 0);
            REQ_OP_MODE        = 1'($urandom);
            REQ_STM_GAIN_MODE  = 1'($urandom);
            REQ_USE_FINISH_IDX = 1'($urandom);
            REQ_FINISH_IDX     = 16'($urandom_range(0, 3));
            STM_IDX            = 16'($urandom_range(0, 3));
            TRIG_40KHZ         = ($urandom_range(0, 29) == 0);
            DIN_VALID          = ($urandom_range(0, 9) != 0);
            RST_N              = ($urandom_range(0, 1999) != 0);
            step();
        end
        RST_N = 1; REQ = 0; TRIG_40KHZ = 0; DIN_VALID = 0;
        step(2);
        cmp_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
